// File: rtl/gpu_regfile.sv
// Multi-context register file with two registered read ports,
// one write port with same-edge bypass and a per-context clear engine.
module gpu_regfile #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int NUM_CTX  = 8,
  parameter int ZERO_REG = 1,
  localparam int REG_W = $clog2(NUM_REGS),
  localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CTX_W-1:0]  wr_ctx,
  input  logic [REG_W-1:0]  wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [CTX_W-1:0]  rd_ctx,
  input  logic [REG_W-1:0]  rd_reg_a,
  input  logic [REG_W-1:0]  rd_reg_b,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              clr_req,
  input  logic [CTX_W-1:0]  clr_ctx,
  output logic              busy,
  output logic              clr_done
);

  localparam int ADDR_W = CTX_W + REG_W;
  localparam int DEPTH  = NUM_CTX * NUM_REGS;
  localparam bit ZR     = (ZERO_REG != 0);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t            state;
  logic [CTX_W-1:0]  clr_ctx_q;
  logic [REG_W-1:0]  idx;
  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic ctx_ok(input logic [CTX_W-1:0] c);
    return 32'(c) < NUM_CTX;
  endfunction

  logic              wr_acc;
  logic              rd_acc;
  logic              clr_we;
  logic              rd_ok;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] nxt_a;
  logic [DATA_W-1:0] nxt_b;

  assign wr_addr   = {wr_ctx, wr_reg};
  assign clr_addr  = {clr_ctx_q, idx};
  assign rd_addr_a = {rd_ctx, rd_reg_a};
  assign rd_addr_b = {rd_ctx, rd_reg_b};
  assign rd_ok     = ctx_ok(rd_ctx);

  assign wr_acc = wr_en && !busy && ctx_ok(wr_ctx)
               && !(ZR && wr_reg == '0);
  assign rd_acc = rd_en && !busy;
  assign clr_we = (state == CLEAR) && ctx_ok(clr_ctx_q);

  // Zero-register and bad-context masks win over the bypass path
  always_comb begin
    nxt_a = mem[rd_addr_a];
    nxt_b = mem[rd_addr_b];
    if (wr_acc && wr_addr == rd_addr_a) nxt_a = wr_data;
    if (wr_acc && wr_addr == rd_addr_b) nxt_b = wr_data;
    if (!rd_ok || (ZR && rd_reg_a == '0)) nxt_a = '0;
    if (!rd_ok || (ZR && rd_reg_b == '0)) nxt_b = '0;
  end

  // Storage is intentionally left out of reset
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      clr_ctx_q <= '0;
      busy      <= 1'b0;
      clr_done  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data_a <= nxt_a;
        rd_data_b <= nxt_b;
      end
      clr_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clr_req) begin
            clr_ctx_q <= clr_ctx;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          idx <= idx + 1'b1;
          if (idx == REG_W'(NUM_REGS - 1)) begin
            busy     <= 1'b0;
            clr_done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_regfile.sv
// Randomized and directed checks of gpu_regfile against an
// array-based model; a second instance covers ZERO_REG=0 and bad contexts.
module tb_gpu_regfile;

  localparam int NR  = 32;
  localparam int NC  = 8;
  localparam int NC2 = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en, clr_req;
  logic [2:0]  wr_ctx, rd_ctx, clr_ctx;
  logic [4:0]  wr_reg, rd_reg_a, rd_reg_b;
  logic [63:0] wr_data;
  logic        rd_valid, busy, clr_done;
  logic [63:0] rd_data_a, rd_data_b;
  logic        rd_valid2, busy2, clr_done2;
  logic [63:0] rd_data_a2, rd_data_b2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpu_regfile dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_ctx(wr_ctx),
    .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_en(rd_en), .rd_ctx(rd_ctx),
    .rd_reg_a(rd_reg_a), .rd_reg_b(rd_reg_b),
    .rd_valid(rd_valid),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .clr_req(clr_req), .clr_ctx(clr_ctx),
    .busy(busy), .clr_done(clr_done)
  );

  gpu_regfile #(.NUM_CTX(NC2), .ZERO_REG(0)) dut2 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_ctx(wr_ctx),
    .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_en(rd_en), .rd_ctx(rd_ctx),
    .rd_reg_a(rd_reg_a), .rd_reg_b(rd_reg_b),
    .rd_valid(rd_valid2),
    .rd_data_a(rd_data_a2), .rd_data_b(rd_data_b2),
    .clr_req(clr_req), .clr_ctx(clr_ctx),
    .busy(busy2), .clr_done(clr_done2)
  );

  // model: [instance][ctx][reg], k marks defined contents
  logic [63:0] m [2][NC][NR];
  bit          k [2][NC][NR];
  logic [64:0] la [2][2];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nctx(int d);
    return (d == 0) ? NC : NC2;
  endfunction

  function automatic logic [64:0] pred(int d, int c, int r);
    if (c >= nctx(d)) return {1'b1, 64'd0};
    if (d == 0 && r == 0) return {1'b1, 64'd0};
    if (wr_en && int'(wr_ctx) == c && int'(wr_reg) == r)
      return {1'b1, wr_data};
    return {k[d][c][r], m[d][c][r]};
  endfunction

  task automatic mwrite();
    for (int d = 0; d < 2; d++) begin
      if (int'(wr_ctx) < nctx(d) && !(d == 0 && wr_reg == 0)) begin
        m[d][wr_ctx][wr_reg] = wr_data;
        k[d][wr_ctx][wr_reg] = 1'b1;
      end
    end
  endtask

  task automatic zap(int c, int upto);
    for (int d = 0; d < 2; d++)
      if (c < nctx(d))
        for (int r = 0; r < upto; r++) begin
          m[d][c][r] = '0;
          k[d][c][r] = 1'b1;
        end
  endtask

  task automatic cycle();
    logic [64:0] p [2][2];
    for (int d = 0; d < 2; d++) begin
      p[d][0] = pred(d, rd_ctx, rd_reg_a);
      p[d][1] = pred(d, rd_ctx, rd_reg_b);
    end
    @(posedge clk);
    if (wr_en) mwrite();
    @(negedge clk);
    chk("rd_valid", 64'(rd_valid), 64'(rd_en));
    chk("rd_valid2", 64'(rd_valid2), 64'(rd_en));
    chk("busy_idle", 64'(busy), 64'd0);
    if (rd_en) la = p;
    if (la[0][0][64]) chk("rd_a", rd_data_a, la[0][0][63:0]);
    if (la[0][1][64]) chk("rd_b", rd_data_b, la[0][1][63:0]);
    if (la[1][0][64]) chk("rd_a2", rd_data_a2, la[1][0][63:0]);
    if (la[1][1][64]) chk("rd_b2", rd_data_b2, la[1][1][63:0]);
  endtask

  task automatic idle_in();
    wr_en = 0; rd_en = 0; clr_req = 0;
  endtask

  task automatic wr(int c, int r, logic [63:0] d);
    wr_en = 1; rd_en = 0;
    wr_ctx = 3'(c); wr_reg = 5'(r); wr_data = d;
    cycle();
    wr_en = 0;
  endtask

  task automatic rd_all(int c);
    for (int r = 0; r < NR; r++) begin
      rd_en = 1; rd_ctx = 3'(c);
      rd_reg_a = 5'(r); rd_reg_b = 5'($urandom_range(0, NR - 1));
      cycle();
    end
    rd_en = 0;
  endtask

  task automatic reset_la();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) la[d][p] = {1'b1, 64'd0};
  endtask

  int nb, nd;

  initial begin
    rst = 1; idle_in();
    wr_ctx = 0; wr_reg = 0; wr_data = 0;
    rd_ctx = 0; rd_reg_a = 0; rd_reg_b = 0; clr_ctx = 0;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NC; c++)
        for (int r = 0; r < NR; r++) k[d][c][r] = 1'b0;
    reset_la();
    @(negedge clk); @(negedge clk);
    chk("rst_rdv", 64'(rd_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(clr_done), 64'd0);
    chk("rst_a", rd_data_a, 64'd0);
    chk("rst_b", rd_data_b, 64'd0);
    rst = 0;
    @(negedge clk);

    // basic write then read
    wr(2, 5, 64'hDEADBEEF_0000_0001);
    rd_en = 1; rd_ctx = 2; rd_reg_a = 5; rd_reg_b = 0;
    cycle(); rd_en = 0;
    chk("d036_a", rd_data_a, 64'hDEADBEEF_0000_0001);

    // same-edge bypass
    wr_en = 1; wr_ctx = 1; wr_reg = 7; wr_data = 64'h55;
    rd_en = 1; rd_ctx = 1; rd_reg_a = 7; rd_reg_b = 0;
    cycle(); idle_in();
    chk("d037_a", rd_data_a, 64'h55);
    chk("d037_b", rd_data_b, 64'h0);

    // zero register
    wr(0, 0, 64'hFF);
    rd_en = 1; rd_ctx = 0; rd_reg_a = 0; rd_reg_b = 0;
    cycle(); rd_en = 0;
    chk("d041_zr1", rd_data_a, 64'h0);
    chk("d041_zr0", rd_data_a2, 64'hFF);

    // random traffic with frequent address collisions
    for (int i = 0; i < 400; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_ctx = 3'($urandom_range(0, 7));
      wr_reg = 5'($urandom_range(0, NR - 1));
      wr_data = {$urandom, $urandom};
      rd_en = 1'($urandom_range(0, 2) != 0);
      rd_ctx = 3'($urandom_range(0, 7));
      rd_reg_a = 5'($urandom_range(0, NR - 1));
      rd_reg_b = 5'($urandom_range(0, NR - 1));
      if ($urandom_range(0, 2) == 0) begin
        rd_ctx = wr_ctx;
        rd_reg_a = wr_reg;
      end
      if ($urandom_range(0, 3) == 0) rd_reg_b = wr_reg;
      if ($urandom_range(0, 7) == 0) rd_reg_b = 0;
      cycle();
    end
    idle_in();

    // full clear with blocked traffic
    for (int r = 0; r < NR; r++) begin
      wr(3, r, {$urandom, $urandom} | 64'd1);
      wr(2, r, {$urandom, $urandom} | 64'd1);
    end
    wr(4, 9, 64'h1234);
    clr_req = 1; clr_ctx = 3;
    @(negedge clk);
    clr_req = 0;
    nb = 0; nd = 0;
    for (int i = 0; i < 60; i++) begin
      nb += int'(busy);
      nd += int'(clr_done);
      chk("clr_rdv", 64'(rd_valid), 64'd0);
      if (i == 5) begin
        wr_en = 1; wr_ctx = 4; wr_reg = 9; wr_data = '1;
        rd_en = 1; rd_ctx = 2; clr_req = 1; clr_ctx = 2;
      end
      if (i == 8) idle_in();
      @(negedge clk);
    end
    chk("busy_cycles", 64'(nb), 64'd32);
    chk("clr_done_cnt", 64'(nd), 64'd1);
    zap(3, NR);
    rd_all(3);
    rd_all(2);
    rd_en = 1; rd_ctx = 4; rd_reg_a = 9; rd_reg_b = 9;
    cycle(); rd_en = 0;
    chk("no_wr_busy", rd_data_a, 64'h1234);

    // reset aborts a clear at index 10
    for (int r = 0; r < NR; r++) wr(3, r, {$urandom, $urandom} | 64'd1);
    clr_req = 1; clr_ctx = 3;
    @(negedge clk);
    clr_req = 0;
    repeat (10) @(negedge clk);
    rst = 1;
    #1;
    chk("ab_busy", 64'(busy), 64'd0);
    chk("ab_rdv", 64'(rd_valid), 64'd0);
    chk("ab_done", 64'(clr_done), 64'd0);
    chk("ab_a", rd_data_a, 64'd0);
    chk("ab_b", rd_data_b2, 64'd0);
    zap(3, 10);
    @(negedge clk);
    rst = 0;
    reset_la();
    rd_all(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
